// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
// Holds FSM state encoding, parameter defaults and a clog2 helper.
package arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int TMAX_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant/done bundle between requesters and the arbiter.
// master: requester side (drives REQ, DONE); slave: arbiter side (drives GNT, GID, BUSY, TOUT).
interface rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = 2
);

    logic [NREQ-1:0] REQ;
    logic            DONE;
    logic [NREQ-1:0] GNT;
    logic [IDW-1:0]  GID;
    logic            BUSY;
    logic            TOUT;

    modport master (
        output REQ, DONE,
        input  GNT, GID, BUSY, TOUT
    );

    modport slave (
        input  REQ, DONE,
        output GNT, GID, BUSY, TOUT
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
// Ports: req, ptr in; pick (one-hot), idx (binary), any (request present) out.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                k;
    int                sum;

    always_comb begin
        // Rotate so that bit ptr lands at position 0.
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        // Fixed priority on the rotated vector, lowest index wins.
        k = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = i;
            end
        end
        // Rotate the winner back into requester numbering.
        sum = int'(ptr) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        idx  = IDW'(sum);
        any  = |req;
        pick = '0;
        if (any) begin
            pick[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-cycle turnaround gap and hold timeout.
// Ports: C clock, R sync active-high reset, bus (slave): REQ/DONE in, GNT/GID/BUSY/TOUT out.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ_DEF),
    parameter int TMAX = TMAX_DEF,
    parameter int TW   = 4
) (
    input  logic         C,
    input  logic         R,
    rr_arbiter_if.slave  bus
);

    state_t          state, n_state;
    logic [NREQ-1:0] gnt,   n_gnt;
    logic [IDW-1:0]  gid,   n_gid;
    logic [IDW-1:0]  ptr,   n_ptr;
    logic [TW-1:0]   cnt,   n_cnt;
    logic            tout,  n_tout;

    logic [NREQ-1:0] pick;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            rel;
    logic            tmo;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (bus.REQ),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge C) begin
        if (R) begin
            state <= IDLE;
            gnt   <= '0;
            gid   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            tout  <= 1'b0;
        end else begin
            state <= n_state;
            gnt   <= n_gnt;
            gid   <= n_gid;
            ptr   <= n_ptr;
            cnt   <= n_cnt;
            tout  <= n_tout;
        end
    end

    always_comb begin
        n_state = state;
        n_gnt   = gnt;
        n_gid   = gid;
        n_ptr   = ptr;
        n_cnt   = cnt;
        n_tout  = 1'b0;
        rel     = bus.DONE | ~bus.REQ[gid];
        tmo     = (cnt == TW'(TMAX));
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    n_gnt   = pick;
                    n_gid   = pick_idx;
                    n_cnt   = '0;
                    n_state = GRANT;
                end
            end
            GRANT: begin
                if (rel || tmo) begin
                    n_gnt   = '0;
                    n_gid   = '0;
                    n_ptr   = (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
                    // A release in the timeout cycle wins: no TOUT pulse.
                    n_tout  = tmo & ~rel;
                    n_state = GAP;
                end else begin
                    n_cnt = tmo ? cnt : cnt + TW'(1);
                end
            end
            GAP: begin
                // Break-before-make cycle; requests are not looked at.
                n_state = IDLE;
            end
            default: begin
                n_gnt   = '0;
                n_gid   = '0;
                n_state = IDLE;
            end
        endcase
    end

    assign bus.GNT  = gnt;
    assign bus.GID  = gid;
    assign bus.BUSY = |gnt;
    assign bus.TOUT = tout;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter.
// Covers reset, rotation, skip/wrap, timeout, REQ-drop release and mid-grant reset.
module tb_rr_arbiter;

    import arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMAX = 15;
    localparam int TW   = 4;

    logic C = 1'b0;
    logic R;

    rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .TMAX (TMAX),
        .TW   (TW)
    ) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    always #5 C = ~C;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic see(input string tag, input logic [3:0] g,
                       input logic [1:0] id, input logic b,
                       input logic t);
        chk({tag, ".gnt"},  32'(bus.GNT),  32'(g));
        chk({tag, ".gid"},  32'(bus.GID),  32'(id));
        chk({tag, ".busy"}, 32'(bus.BUSY), 32'(b));
        chk({tag, ".tout"}, 32'(bus.TOUT), 32'(t));
    endtask

    // Entered in an IDLE cycle: grant, hold 3 cycles, DONE, gap x2.
    task automatic serve(input string tag, input logic [3:0] g,
                         input logic [1:0] id, input logic [3:0] nreq);
        step();
        see({tag, ".g"}, g, id, 1'b1, 1'b0);
        step();
        step();
        see({tag, ".h"}, g, id, 1'b1, 1'b0);
        bus.DONE = 1'b1;
        step();
        bus.DONE = 1'b0;
        bus.REQ  = nreq;
        see({tag, ".gap"}, 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        see({tag, ".idle"}, 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        R        = 1'b1;
        bus.REQ  = 4'b1111;
        bus.DONE = 1'b0;
        step();
        see("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        see("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
        R = 1'b0;

        serve("rot0", 4'b0001, 2'd0, 4'b1111);
        serve("rot1", 4'b0010, 2'd1, 4'b1111);
        serve("rot2", 4'b0100, 2'd2, 4'b1111);
        serve("rot3", 4'b1000, 2'd3, 4'b1111);
        serve("rot4", 4'b0001, 2'd0, 4'b1111);
        serve("rot5", 4'b0010, 2'd1, 4'b1111);
        serve("rot6", 4'b0100, 2'd2, 4'b0101);
        serve("skip", 4'b0001, 2'd0, 4'b0101);
        serve("wrap", 4'b0100, 2'd2, 4'b0110);

        // PTR=3, REQ=0110: requester 1 wins and never releases.
        step();
        for (int i = 0; i < 16; i++) begin
            see($sformatf("to.h%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
            step();
        end
        see("to.rev", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        see("to.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        see("to.next", 4'b0100, 2'd2, 1'b1, 1'b0);

        bus.REQ = 4'b0000;
        step();
        see("drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        see("drop.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.DONE = 1'b1;
        step();
        see("idle.done1", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        see("idle.done2", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.DONE = 1'b0;
        bus.REQ  = 4'b1111;
        step();
        see("ptr.kept", 4'b1000, 2'd3, 1'b1, 1'b0);

        step();
        R = 1'b1;
        step();
        see("rst.mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        R       = 1'b0;
        bus.REQ = 4'b1001;
        step();
        see("rst.ptr", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Release coinciding with the timeout cycle.
        for (int i = 0; i < 15; i++) begin
            step();
        end
        see("dt.h", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.DONE = 1'b1;
        step();
        bus.DONE = 1'b0;
        see("dt.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        see("dt.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
